expr_feeder: RTL and testbench
==============================

# expr_feeder

Upstream framing stage for the arithmetic expression calculator. Accepts an ASCII expression byte-by-byte over a valid/ready handshake and buffers it up to and including the terminating `=` (0x3D). It checks the frame for legal characters, balanced parentheses, length and emptiness. A good frame is replayed to the calculator one character per cycle with a first-character `ready` strobe. The block then waits for the calculator's `valid` before accepting the next frame.

## Interface
- `DEPTH`, 16: buffer entries, `=` included; max expression length is DEPTH-1 characters plus `=`.
- `TIMEOUT`, 255: WAIT watchdog limit in cycles; used only with FEEDER_TIMEOUT_EN.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  upstream byte valid.
- `in_data`  in  8  upstream ASCII byte.
- `in_ready`  out  1  block accepts a byte this cycle.
- `ascii_out`  out  8  character to calculator `ascii_in`.
- `out_ready`  out  1  one-cycle strobe marking the first character of a frame; drives calculator `ready`.
- `aec_valid`  in  1  calculator result-valid pulse.
- `busy`  out  1  high whenever state is not COLLECT.
- `err`  out  1  one-cycle pulse when a frame is dropped.
- `err_code`  out  2  error cause, held until the next err: 0 illegal char, 1 paren, 2 overflow, 3 empty/timeout.

## Operation
- States: COLLECT, SEND, WAIT.
- Reset values: state COLLECT, ascii_out 0x00, out_ready 0, err 0, err_code 0, busy 0. All counters and flags are 0.
- **COLLECT**
  - in_ready=1. A byte is accepted on in_valid && in_ready.
  - Legal bytes: `0`-`9`, `a`-`f`, `(`, `)`, `*`, `+`, `-`, `=`.
  - Each accepted non-`=` byte is written to buf[wr], and wr increments.
  - Paren depth: +1 on `(`, -1 on `)`, 4-bit saturating.
  - Error flags are sticky within a frame. Only the first error is recorded.
    - Illegal byte: code 0.
    - `)` at depth 0: code 1.
    - Non-`=` byte arriving with wr==DEPTH-1: code 2. The byte is discarded and wr does not advance.
  - On accepting `=`:
    - wr==0 gives code 3. Depth≠0 gives code 1, unless an earlier error is already recorded.
    - If any error is set: pulse err, latch err_code, clear wr/depth/flags, stay in COLLECT.
    - Otherwise: store `=` at buf[wr]. Load ascii_out←buf[0] and out_ready←1. Set rd←1 and enter SEND. For the single-character frame case, buf[0] is the first stored character.
- **SEND**
  - in_ready=0.
  - Each edge: ascii_out←buf[rd], out_ready←0, rd increments.
  - After the edge that presents `=`, the next edge sets ascii_out←0x00 and enters WAIT.
  - An L-character frame (`=` included) occupies exactly L consecutive output cycles.
- **WAIT**
  - in_ready=0, ascii_out=0x00.
  - aec_valid=1: clear wr/rd/depth/flags and enter COLLECT on the next edge.
- aec_valid is ignored in COLLECT and SEND.
- ascii_out is never 0x3D outside the single `=` cycle of SEND. The calculator must not see `=` while idle.

## Timing
- All outputs are registered except in_ready and busy, which decode state.
- If `=` is accepted at edge E, the first character appears after E with out_ready high for exactly that cycle.
- err is high for one cycle after the edge that accepted the faulty frame's `=`.
- Back-to-back input: one byte per cycle in COLLECT with no bubbles.
- A byte offered in SEND/WAIT is not accepted. Upstream holds it because in_ready=0.
- An aec_valid pulse in WAIT gives in_ready=1 on the following cycle.
- rst mid-frame, in any state: immediate return to reset values. The partial frame is lost and no err is raised.

## Configuration
- `FEEDER_TIMEOUT_EN` defined: a counter runs in WAIT. If it reaches TIMEOUT cycles without aec_valid, the block pulses err with err_code 3, clears state and returns to COLLECT. The counter clears on entering WAIT.
- Not defined: WAIT holds indefinitely until aec_valid. No counter logic is present.

## Test plan
- `3+4=` back-to-back: ascii_out 0x33,0x2B,0x34,0x3D on four consecutive cycles starting the cycle after `=` is accepted. out_ready is high on the 0x33 cycle only, then ascii_out is 0x00. busy=1 and in_ready=0 until an aec_valid pulse, then in_ready=1 the next cycle.
- `(1+2=`: err pulse with err_code=1, no out_ready, in_ready stays 1. Next frame `2*3=` replays normally.
- `1)+(2=`: err_code=1 from the underflow. `1#2=`: err_code=0.
- 15 digits + `=`: replayed over 16 cycles. 16 digits + `=`: err_code=2, nothing sent.
- `=` alone: err_code=3. rst asserted mid-SEND of `9-1=`: ascii_out=0x00, out_ready=0, in_ready=1 immediately.
- FEEDER_TIMEOUT_EN, TIMEOUT=8: send `5=` and withhold aec_valid. err pulses with err_code=3 eight cycles after entering WAIT, then in_ready=1.

Source files
------------

// File: rtl/expr_feeder.sv
// expr_feeder: framing stage ahead of the expression calculator.
// Collects an ASCII expression up to the terminating '=', validates it
// (legal characters, balanced parentheses, length, emptiness), replays a
// good frame one character per cycle with a first-character strobe, then
// waits for the calculator's result-valid before taking the next frame.
// Optional build macro FEEDER_TIMEOUT_EN adds a watchdog on the WAIT state
// that drops the frame with err_code 3 after TIMEOUT cycles.
module expr_feeder #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] ascii_out,
  output logic       out_ready,
  input  logic       aec_valid,
  output logic       busy,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [7:0] CH_EQ = 8'h3D;
  localparam logic [7:0] CH_LP = 8'h28;
  localparam logic [7:0] CH_RP = 8'h29;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SEND    = 2'd1,
    WAIT    = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr;
  logic [AW-1:0] rd;
  logic [3:0]    depth;
  logic          flag;
  logic [1:0]    fcode;

  logic          accept;
  logic          is_eq;
  logic          full;
  logic          nb_err;
  logic [1:0]    nb_code;
  logic          eq_err;
  logic [1:0]    eq_code;
  logic          send_last;
  logic          mem_we;
  logic          tmo;

  // Character set the calculator understands ('=' included).
  function automatic logic char_legal(input logic [7:0] c);
    char_legal = ((c >= 8'h30) && (c <= 8'h39)) ||
                 ((c >= 8'h61) && (c <= 8'h66)) ||
                 (c == CH_LP) || (c == CH_RP) ||
                 (c == 8'h2A) || (c == 8'h2B) || (c == 8'h2D) ||
                 (c == CH_EQ);
  endfunction

  // Parenthesis depth tracking, saturating at both ends of the 4-bit range.
  function automatic logic [3:0] depth_step(input logic [3:0] d, input logic [7:0] c);
    depth_step = d;
    if ((c == CH_LP) && (d != 4'd15)) depth_step = d + 4'd1;
    else if ((c == CH_RP) && (d != 4'd0)) depth_step = d - 4'd1;
  endfunction

  assign accept    = in_valid && (state == COLLECT);
  assign is_eq     = (in_data == CH_EQ);
  assign full      = (wr == AW'(DEPTH - 1));
  assign send_last = (state == SEND) && (ascii_out == CH_EQ);

  // A frame is bad at '=' if an earlier error is pending, it is empty, or
  // its parentheses are left open; the earliest cause wins.
  assign eq_err  = flag || (wr == '0) || (depth != 4'd0);
  assign eq_code = flag ? fcode : ((wr == '0) ? 2'd3 : 2'd1);

  // Only store a byte that will be kept: a non-'=' byte while room remains,
  // or the '=' that closes a good frame.
  assign mem_we = accept && (is_eq ? !eq_err : !full);

  // Classify a non-'=' byte: overflow outranks content checks because the
  // byte is discarded anyway.
  always_comb begin
    nb_err  = 1'b0;
    nb_code = 2'd0;
    if (full) begin
      nb_err  = 1'b1;
      nb_code = 2'd2;
    end else if (!char_legal(in_data)) begin
      nb_err  = 1'b1;
      nb_code = 2'd0;
    end else if ((in_data == CH_RP) && (depth == 4'd0)) begin
      nb_err  = 1'b1;
      nb_code = 2'd1;
    end
  end

`ifdef FEEDER_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] tcnt;

  // Watchdog counts cycles spent in WAIT and is cleared everywhere else,
  // so it restarts from zero on every entry to WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                tcnt <= '0;
    else if (state == WAIT) tcnt <= tcnt + 1'b1;
    else                    tcnt <= '0;
  end

  assign tmo = (state == WAIT) && !aec_valid && (tcnt == TW'(TIMEOUT - 1));
`else
  // Without the watchdog WAIT only ends on aec_valid; TIMEOUT is inert.
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign tmo = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_nx;
  end

  // Next-state decode plus the state-decoded handshake outputs.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b1;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (accept && is_eq && !eq_err) state_nx = SEND;
      end
      SEND: begin
        if (send_last) state_nx = WAIT;
      end
      WAIT: begin
        if (aec_valid || tmo) state_nx = COLLECT;
      end
      default: state_nx = COLLECT;
    endcase
  end

  // Frame buffer; contents need no reset since wr/rd gate every access.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr] <= in_data;
  end

  // Pointers, validation flags and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr        <= '0;
      rd        <= '0;
      depth     <= 4'd0;
      flag      <= 1'b0;
      fcode     <= 2'd0;
      ascii_out <= 8'h00;
      out_ready <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      err <= 1'b0;
      case (state)
        COLLECT: begin
          if (accept) begin
            if (is_eq) begin
              if (eq_err) begin
                err      <= 1'b1;
                err_code <= eq_code;
                wr       <= '0;
                depth    <= 4'd0;
                flag     <= 1'b0;
              end else begin
                ascii_out <= mem[0];
                out_ready <= 1'b1;
                rd        <= AW'(1);
              end
            end else begin
              if (!full) begin
                wr    <= wr + 1'b1;
                depth <= depth_step(depth, in_data);
              end
              if (nb_err && !flag) begin
                flag  <= 1'b1;
                fcode <= nb_code;
              end
            end
          end
        end
        SEND: begin
          out_ready <= 1'b0;
          if (send_last) begin
            ascii_out <= 8'h00;
          end else begin
            ascii_out <= mem[rd];
            rd        <= rd + 1'b1;
          end
        end
        WAIT: begin
          if (aec_valid || tmo) begin
            wr    <= '0;
            rd    <= '0;
            depth <= 4'd0;
            flag  <= 1'b0;
          end
          if (tmo) begin
            err      <= 1'b1;
            err_code <= 2'd3;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_expr_feeder.sv
// tb_expr_feeder: self-checking bench for expr_feeder. A frame-level model
// judges each complete frame and queues the characters that must be
// replayed; a compare process checks every output on every falling edge.
// Directed frames with literal expectations are followed by random frames.
module tb_expr_feeder;

  localparam int DEPTH = 16;
  localparam int TMO   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       aec_valid = 1'b0;
  logic       in_ready;
  logic [7:0] ascii_out;
  logic       out_ready;
  logic       busy;
  logic       err;
  logic [1:0] err_code;

  int vectors = 0;
  int miscmp  = 0;

  expr_feeder #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ascii_out(ascii_out), .out_ready(out_ready),
    .aec_valid(aec_valid), .busy(busy), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // mode: 0 collecting, 1 replaying, 2 waiting for the calculator
  int         mode = 0;
  logic [7:0] frm[$];
  logic [7:0] outq[$];
  logic [7:0] e_ascii = 8'h00;
  bit         e_ordy = 1'b0;
  bit         e_err = 1'b0;
  logic [1:0] e_code = 2'd0;
  int         wcnt = 0;
  int         verdict;

  function automatic bit legal_ch(input logic [7:0] c);
    string s;
    s = "0123456789abcdef()*+-";
    for (int i = 0; i < s.len(); i++) if (s[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  // Judge the collected frame (without its '='): -1 if good, else the code
  // of the earliest problem.
  function automatic int judge();
    int stored = 0;
    int dep = 0;
    int code = -1;
    foreach (frm[i]) begin
      if (stored >= DEPTH - 1) begin
        if (code < 0) code = 2;
      end else begin
        stored++;
        if (!legal_ch(frm[i])) begin
          if (code < 0) code = 0;
        end else if (frm[i] == 8'h28) dep++;
        else if (frm[i] == 8'h29) begin
          if (dep == 0) begin
            if (code < 0) code = 1;
          end else dep--;
        end
      end
    end
    if (code < 0) begin
      if (stored == 0) code = 3;
      else if (dep != 0) code = 1;
    end
    return code;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mode = 0; frm.delete(); outq.delete();
      e_ascii = 8'h00; e_ordy = 1'b0; e_err = 1'b0; e_code = 2'd0; wcnt = 0;
    end else begin
      e_err = 1'b0;
      case (mode)
        0: if (in_valid) begin
          if (in_data != 8'h3D) frm.push_back(in_data);
          else begin
            verdict = judge();
            if (verdict >= 0) begin
              e_err = 1'b1; e_code = verdict[1:0];
            end else begin
              outq = frm;
              outq.push_back(8'h3D);
              e_ascii = outq.pop_front();
              e_ordy = 1'b1;
              mode = 1;
            end
            frm.delete();
          end
        end
        1: begin
          e_ordy = 1'b0;
          if (outq.size() > 0) e_ascii = outq.pop_front();
          else begin e_ascii = 8'h00; mode = 2; wcnt = 0; end
        end
        default: begin
          if (aec_valid) mode = 0;
`ifdef FEEDER_TIMEOUT_EN
          else if (wcnt == TMO - 1) begin e_err = 1'b1; e_code = 2'd3; mode = 0; end
          else wcnt++;
`endif
        end
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    vectors++;
    if (ascii_out !== e_ascii || out_ready !== e_ordy || err !== e_err ||
        err_code !== e_code || in_ready !== (mode == 0) || busy !== (mode != 0)) begin
      miscmp++;
      $display("FAIL cycle @%0t: ascii=%h want %h ordy=%b want %b err=%b want %b code=%0d want %0d in_ready=%b busy=%b want mode %0d",
               $time, ascii_out, e_ascii, out_ready, e_ordy, err, e_err,
               err_code, e_code, in_ready, busy, mode);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_aec();
    aec_valid = 1'b1;
    @(posedge clk); #1;
    aec_valid = 1'b0;
  endtask

  // Offer each byte until accepted; returns at #1 after the accepting edge.
  task automatic send_frame(input logic [7:0] q[$], input bit gaps);
    bit acc;
    int n;
    foreach (q[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        idle($urandom_range(1, 2));
      end
      in_valid = 1'b1;
      in_data  = q[i];
      n = 0;
      acc = 1'b0;
      while (!acc && n < 300) begin
        @(negedge clk); acc = in_ready;
        @(posedge clk); #1;
        n++;
      end
      if (!acc) begin
        vectors++; miscmp++;
        $display("FAIL accept_timeout: byte %h not accepted within %0d cycles", q[i], n);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    logic [7:0] q[$];
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    send_frame(q, 1'b0);
  endtask

  task automatic finish_frame();
    idle(20);
    pulse_aec();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    string legal_s;
    string bad_s;
    logic [7:0] q[$];
    int len;
    legal_s = "0123456789abcdef()*+-";
    bad_s   = "#x /gz";

    // reset state
    idle(2);
    @(negedge clk);
    chk("rst_ascii", ascii_out, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    @(negedge clk);
    chk("idle_in_ready", {7'd0, in_ready}, 8'h01);
    @(posedge clk); #1;

    // 3+4= replay
    send_str("3+4=");
    @(negedge clk); chk("r0", ascii_out, 8'h33); chk("r0_ordy", {7'd0, out_ready}, 8'h01);
    @(negedge clk); chk("r1", ascii_out, 8'h2B); chk("r1_ordy", {7'd0, out_ready}, 8'h00);
    @(negedge clk); chk("r2", ascii_out, 8'h34);
    @(negedge clk); chk("r3", ascii_out, 8'h3D);
    @(negedge clk); chk("r4_idle", ascii_out, 8'h00); chk("wait_in_ready", {7'd0, in_ready}, 8'h00);
    @(posedge clk); #1;
    pulse_aec();
    @(negedge clk); chk("post_aec_in_ready", {7'd0, in_ready}, 8'h01);
    @(posedge clk); #1;

    // open paren, then good frame
    send_str("(1+2=");
    @(negedge clk); chk("paren_err", {7'd0, err}, 8'h01); chk("paren_code", {6'd0, err_code}, 8'h01);
    chk("paren_in_ready", {7'd0, in_ready}, 8'h01);
    @(posedge clk); #1;
    send_str("2*3=");
    @(negedge clk); chk("after_err_first", ascii_out, 8'h32);
    @(posedge clk); #1;
    finish_frame();

    send_str("1)+(2=");
    @(negedge clk); chk("underflow_code", {6'd0, err_code}, 8'h01);
    @(posedge clk); #1;
    send_str("1#2=");
    @(negedge clk); chk("illegal_code", {6'd0, err_code}, 8'h00);
    @(posedge clk); #1;

    // longest good frame, then one too long
    send_str("123456789012345=");
    @(negedge clk); chk("long_first", ascii_out, 8'h31);
    repeat (14) @(negedge clk);
    @(negedge clk); chk("long_eq", ascii_out, 8'h3D);
    @(negedge clk); chk("long_idle", ascii_out, 8'h00);
    @(posedge clk); #1;
    finish_frame();
    send_str("1234567890123456=");
    @(negedge clk); chk("overflow_code", {6'd0, err_code}, 8'h02);
    chk("overflow_ordy", {7'd0, out_ready}, 8'h00);
    @(posedge clk); #1;

    send_str("=");
    @(negedge clk); chk("empty_code", {6'd0, err_code}, 8'h03);
    @(posedge clk); #1;

    // reset in the middle of a replay
    send_str("9-1=");
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_ascii", ascii_out, 8'h00);
    chk("midrst_ordy", {7'd0, out_ready}, 8'h00);
    chk("midrst_in_ready", {7'd0, in_ready}, 8'h01);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

`ifdef FEEDER_TIMEOUT_EN
    // watchdog: '=' at edge E, WAIT from E+2, err after edge E+10
    send_str("5=");
    repeat (10) @(negedge clk);
    @(negedge clk);
    chk("tmo_err", {7'd0, err}, 8'h01);
    chk("tmo_code", {6'd0, err_code}, 8'h03);
    chk("tmo_in_ready", {7'd0, in_ready}, 8'h01);
    @(posedge clk); #1;
`endif

    // random frames
    for (int f = 0; f < 150; f++) begin
      q.delete();
      len = $urandom_range(0, 17);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 19) == 0) q.push_back(bad_s[$urandom_range(0, 5)]);
        else q.push_back(legal_s[$urandom_range(0, 20)]);
      end
      q.push_back(8'h3D);
      send_frame(q, 1'b1);
      if ($urandom_range(0, 2) == 0) pulse_aec();
      idle($urandom_range(18, 25));
      pulse_aec();
    end

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
    $finish;
  end

endmodule
